// File: rtl/text_banner_rom_if.sv
// Pixel request / colour response bundle between the VGA scanner and text_banner_rom.
interface text_banner_rom_if #(
    parameter int XW = 6
);
    logic [XW-1:0] x;
    logic [2:0]    y;
    logic [1:0]    msg_sel;
    logic          frame_tick;
    logic          blink_en;
    logic          scroll_en;
    logic [11:0]   color;
    logic          color_vld;

    modport master (output x, y, msg_sel, frame_tick, blink_en, scroll_en,
                    input  color, color_vld);
    modport slave  (input  x, y, msg_sel, frame_tick, blink_en, scroll_en,
                    output color, color_vld);
endinterface

// File: rtl/text_banner_rom.sv
// Banner pixel source: message table + 5x7 font, with per-frame blink and wrapping scroll.
// Two-stage pipeline (glyph lookup, then colour select), no stall.
module text_banner_rom #(
    parameter int          MSG_LEN       = 4,
    parameter int          XW            = 6,
    parameter int          BLINK_FRAMES  = 30,
    parameter int          SCROLL_FRAMES = 4,
    parameter logic [11:0] FG_COLOR      = 12'hF00,
    parameter logic [11:0] BG_COLOR      = 12'h000,
    parameter logic [11:0] WARN_COLOR    = 12'hF0F
) (
    input  logic               clk,
    input  logic               rst,
    text_banner_rom_if.slave   bus
);
    localparam int W   = 7 * MSG_LEN;
    localparam int EW  = XW + 1;
    localparam int BCW = (BLINK_FRAMES  > 1) ? $clog2(BLINK_FRAMES)  : 1;
    localparam int SCW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    // Column data packed {col5,col4,col3,col2,col1}; bit y of a column byte is row y.
    function automatic logic [7:0] font_col(input logic [3:0] code, input logic [2:0] col);
        logic [39:0] g;
        int          c;
        case (code)
            4'd1:    g = 40'h7E_09_09_09_7E; // A
            4'd2:    g = 40'h41_49_49_49_7F; // E
            4'd3:    g = 40'h3A_49_49_41_3E; // G
            4'd4:    g = 40'h41_41_7F_41_41; // I
            4'd5:    g = 40'h40_40_40_40_7F; // L
            4'd6:    g = 40'h7F_02_0C_02_7F; // M
            4'd7:    g = 40'h7F_08_04_02_7F; // N
            4'd8:    g = 40'h3E_41_41_41_3E; // O
            4'd9:    g = 40'h46_29_19_09_7F; // R
            4'd10:   g = 40'h31_49_49_49_46; // S
            4'd11:   g = 40'h1F_20_40_20_1F; // V
            4'd12:   g = 40'h7F_20_18_20_7F; // W
            default: g = 40'h0;             // space and unused codes
        endcase
        c = int'(col) - 1;
        font_col = (c >= 0 && c <= 4) ? g[8*c +: 8] : 8'h00;
    endfunction

    // Glyph codes, slot 0 in the low nibble; slots past the fourth are spaces.
    function automatic logic [3:0] msg_glyph(input logic [1:0] m, input int i);
        logic [15:0] s;
        case (m)
            2'd0:    s = 16'h2A85; // L O S E
            2'd1:    s = 16'h074C; // W I N _
            2'd2:    s = 16'h2613; // G A M E
            default: s = 16'h92B8; // O V E R
        endcase
        msg_glyph = (i >= 0 && i < 4) ? s[4*i +: 4] : 4'd0;
    endfunction

    logic [1:0]     act_msg_q, act_msg_d;
    logic [XW-1:0]  scroll_off_q, scroll_off_d;
    logic [SCW-1:0] scroll_cnt_q, scroll_cnt_d;
    logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
    logic           visible_q, visible_d;

    always_comb begin
        act_msg_d    = act_msg_q;
        scroll_off_d = scroll_off_q;
        scroll_cnt_d = scroll_cnt_q;
        blink_cnt_d  = blink_cnt_q;
        visible_d    = visible_q;
        if (bus.frame_tick) act_msg_d = bus.msg_sel;

        // A message change restarts the scroll and wins over a step on the same tick.
        if (!bus.scroll_en) begin
            scroll_off_d = '0;
            scroll_cnt_d = '0;
        end else if (bus.frame_tick) begin
            if (bus.msg_sel != act_msg_q) begin
                scroll_off_d = '0;
                scroll_cnt_d = '0;
            end else if (scroll_cnt_q == SCW'(SCROLL_FRAMES - 1)) begin
                scroll_cnt_d = '0;
                scroll_off_d = (scroll_off_q == XW'(W - 1)) ? '0 : scroll_off_q + 1'b1;
            end else begin
                scroll_cnt_d = scroll_cnt_q + 1'b1;
            end
        end

        if (!bus.blink_en) begin
            visible_d   = 1'b1;
            blink_cnt_d = '0;
        end else if (bus.frame_tick) begin
            if (blink_cnt_q == BCW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                visible_d   = ~visible_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    logic [EW-1:0] ex_sum, ex;
    logic [3:0]    glyph_q, glyph_d;
    logic [2:0]    gcol_q, gcol_d;
    logic [2:0]    y_q;
    logic          oor_q, oor_d;
    logic          vis1_q;
    logic          vld1_q;

    // Index/column by comparing against each glyph's start column, no divider.
    always_comb begin
        int gi;
        ex_sum = {1'b0, bus.x} + {1'b0, scroll_off_q};
        ex     = (ex_sum >= EW'(W)) ? ex_sum - EW'(W) : ex_sum;
        gi     = 0;
        gcol_d = ex[2:0];
        for (int g = 0; g < MSG_LEN; g++) begin
            if (ex >= EW'(7 * g)) begin
                gi     = g;
                gcol_d = 3'(ex - EW'(7 * g));
            end
        end
        glyph_d = msg_glyph(act_msg_q, gi);
        oor_d   = ({1'b0, bus.x} >= EW'(W));
    end

    logic [7:0]  col_bits;
    logic [11:0] color_q, color_d;
    logic        color_vld_q;

    always_comb begin
        col_bits = font_col(glyph_q, gcol_q);
        if (oor_q)                       color_d = WARN_COLOR;
        else if (col_bits[y_q] && vis1_q) color_d = FG_COLOR;
        else                             color_d = BG_COLOR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_msg_q    <= '0;
            scroll_off_q <= '0;
            scroll_cnt_q <= '0;
            blink_cnt_q  <= '0;
            visible_q    <= 1'b1;
            glyph_q      <= '0;
            gcol_q       <= '0;
            y_q          <= '0;
            oor_q        <= 1'b0;
            vis1_q       <= 1'b1;
            vld1_q       <= 1'b0;
            color_q      <= BG_COLOR;
            color_vld_q  <= 1'b0;
        end else begin
            act_msg_q    <= act_msg_d;
            scroll_off_q <= scroll_off_d;
            scroll_cnt_q <= scroll_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            visible_q    <= visible_d;
            glyph_q      <= glyph_d;
            gcol_q       <= gcol_d;
            y_q          <= bus.y;
            oor_q        <= oor_d;
            vis1_q       <= visible_q;
            vld1_q       <= 1'b1;
            color_q      <= color_d;
            color_vld_q  <= vld1_q;
        end
    end

    assign bus.color     = color_q;
    assign bus.color_vld = color_vld_q;
endmodule

// File: tb/tb_text_banner_rom.sv
// Randomized scoreboard bench for text_banner_rom against a row-bitmap banner model.
module tb_text_banner_rom;
    localparam int          XW = 6, MSG_LEN = 4, W = 28, BF = 30, SF = 4;
    localparam logic [11:0] FG = 12'hF00, BG = 12'h000, WARN = 12'hF0F;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    text_banner_rom_if #(.XW(XW)) bus ();

    text_banner_rom #(
        .MSG_LEN(MSG_LEN), .XW(XW), .BLINK_FRAMES(BF), .SCROLL_FRAMES(SF),
        .FG_COLOR(FG), .BG_COLOR(BG), .WARN_COLOR(WARN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [11:0] c;
        int          x;
        int          y;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  mon_e;
    int    n_chk  = 0;
    int    n_fail = 0;
    bit    mon_en = 1'b1;
    string msgs[4] = '{"LOSE", "WIN ", "GAME", "OVER"};

    // Model state: frame ticks counted since the last scroll/blink restart.
    int m_msg = 0, s_ticks = 0, b_ticks = 0;

    // Seven 5-pixel rows, top row in the high bits, leftmost pixel first.
    function automatic logic [34:0] glyph_rows(byte ch);
        case (ch)
            "A": return 35'b01110_10001_10001_11111_10001_10001_10001;
            "E": return 35'b11111_10000_10000_11110_10000_10000_11111;
            "G": return 35'b01110_10001_10000_10111_10001_10001_01110;
            "I": return 35'b11111_00100_00100_00100_00100_00100_11111;
            "L": return 35'b10000_10000_10000_10000_10000_10000_11111;
            "M": return 35'b10001_11011_10101_10101_10001_10001_10001;
            "N": return 35'b10001_11001_10101_10011_10001_10001_10001;
            "O": return 35'b01110_10001_10001_10001_10001_10001_01110;
            "R": return 35'b11110_10001_10001_11110_10100_10010_10001;
            "S": return 35'b01111_10000_10000_01110_00001_00001_11110;
            "V": return 35'b10001_10001_10001_10001_10001_01010_00100;
            "W": return 35'b10001_10001_10001_10101_10101_11011_10001;
            default: return 35'b0;
        endcase
    endfunction

    function automatic logic [11:0] model_pixel(int x, int y);
        int          ex, c, off;
        bit          vis;
        string       s;
        logic [34:0] rows;
        if (x >= W) return WARN;
        off = (s_ticks / SF) % W;
        vis = ((b_ticks / BF) % 2) == 0;
        ex  = (x + off) % W;
        c   = ex % 7;
        if (c == 0 || c == 6 || y == 7 || !vis) return BG;
        s    = msgs[m_msg];
        rows = glyph_rows(s[ex / 7]);
        return rows[35 - 5 * y - c] ? FG : BG;
    endfunction

    task automatic step(int x, int y, int msel, bit tick, bit ben, bit sen);
        exp_t e;
        bus.x          = XW'(x);
        bus.y          = 3'(y);
        bus.msg_sel    = 2'(msel);
        bus.frame_tick = tick;
        bus.blink_en   = ben;
        bus.scroll_en  = sen;
        e.c = model_pixel(x, y);
        e.x = x;
        e.y = y;
        exp_q.push_back(e);
        if (!sen) s_ticks = 0;
        else if (tick) s_ticks = (msel != m_msg) ? 0 : s_ticks + 1;
        if (!ben) b_ticks = 0;
        else if (tick) b_ticks++;
        if (tick) m_msg = msel;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, int got, int want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Release reset and confirm color_vld rises on exactly the second edge.
    task automatic release_rst();
        rst = 1'b0;
        step(0, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("vld_after_1_edge", int'(bus.color_vld), 0);
        step(1, 3, 0, 1'b0, 1'b0, 1'b0);
        chk("vld_after_2_edges", int'(bus.color_vld), 1);
    endtask

    task automatic rand_run(int n, int tick_div, bit force_ben, bit force_sen);
        int msel = $urandom_range(0, 3);
        bit ben  = force_ben;
        bit sen  = force_sen;
        for (int i = 0; i < n; i++) begin
            int x;
            x = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 30);
            if ($urandom_range(0, 29) == 0) msel = $urandom_range(0, 3);
            if (!force_ben && $urandom_range(0, 59) == 0) ben = ~ben;
            if (!force_sen && $urandom_range(0, 59) == 0) sen = ~sen;
            step(x, $urandom_range(0, 7), msel, ($urandom_range(0, tick_div - 1) == 0), ben, sen);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst && bus.color_vld) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pixel: color=%h with nothing expected", bus.color);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.color !== mon_e.c) begin
                    n_fail++;
                    $display("FAIL pixel x=%0d y=%0d: got %h expected %h",
                             mon_e.x, mon_e.y, bus.color, mon_e.c);
                end
            end
        end
    end

    initial begin
        bus.x = '0; bus.y = '0; bus.msg_sel = '0;
        bus.frame_tick = 1'b0; bus.blink_en = 1'b0; bus.scroll_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_color", int'(bus.color), int'(BG));
        chk("reset_vld", int'(bus.color_vld), 0);
        @(posedge clk);
        #1;
        release_rst();

        // 'L' stem, foot, blank separator column, range edge.
        for (int y = 0; y < 7; y++) step(1, y, 0, 1'b0, 1'b0, 1'b0);
        step(2, 6, 0, 1'b0, 1'b0, 1'b0);
        step(2, 0, 0, 1'b0, 1'b0, 1'b0);
        step(0, 4, 0, 1'b0, 1'b0, 1'b0);
        for (int y = 0; y < 8; y++) step(28, y, 0, 1'b0, 1'b0, 1'b0);
        for (int y = 0; y < 8; y++) step(27, y, 0, 1'b0, 1'b0, 1'b0);
        step(1, 7, 0, 1'b0, 1'b0, 1'b0);

        // Message change mid-frame only lands on the tick, and clears a scroll.
        for (int i = 0; i < 8; i++) step(i, 5, 0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step($urandom_range(0, 27), $urandom_range(0, 6), 1, 1'b0, 1'b0, 1'b1);
        step(0, 3, 1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step($urandom_range(0, 27), $urandom_range(0, 6), 1, 1'b0, 1'b0, 1'b1);

        // Scroll a full wrap with a tick every cycle, then blink through two half-periods.
        rand_run(130, 1, 1'b0, 1'b1);
        rand_run(140, 2, 1'b1, 1'b0);
        rand_run(900, 3, 1'b0, 1'b0);

        // Reset mid-stream.
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        chk("midreset_color", int'(bus.color), int'(BG));
        chk("midreset_vld", int'(bus.color_vld), 0);
        m_msg = 0; s_ticks = 0; b_ticks = 0;
        @(posedge clk);
        #1;
        release_rst();
        rand_run(900, 2, 1'b0, 1'b0);

        for (int i = 0; i < 8 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        mon_en = 1'b0;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL timeout: bench did not finish in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
